// File: rtl/adder_hex_scan_display_if.sv
// Operand/sum and display-pin bundle for the hex adder display block.
// The master side drives operands; the slave side is the display block.
interface adder_hex_scan_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              c_in;
    logic              load;
    logic [WIDTH:0]    sum;
    logic              sum_valid;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;

    modport master (
        output a, b, c_in, load,
        input  sum, sum_valid, an, seg
    );

    modport slave (
        input  a, b, c_in, load,
        output sum, sum_valid, an, seg
    );
endinterface

// File: rtl/adder_hex_scan_display.sv
// Captures A+B+Cin on a load strobe and shows the registered sum in hex on a
// time-multiplexed, active-low common-anode seven-segment bank.
module adder_hex_scan_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 4,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    adder_hex_scan_display_if.slave  bus
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PAD_W = 4 * DIGITS;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    if (WIDTH < 2) begin : g_bad_width
        $error("adder_hex_scan_display: WIDTH must be >= 2");
    end
    if (4 * DIGITS < WIDTH + 1) begin : g_bad_digits
        $error("adder_hex_scan_display: DIGITS too small to show WIDTH+1 sum bits");
    end
    if (REFRESH_DIV < 1) begin : g_bad_div
        $error("adder_hex_scan_display: REFRESH_DIV must be >= 1");
    end

    // Active-low gfedcba hex glyphs.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    logic [WIDTH:0]     sum_r;
    logic               sum_valid_r;
    logic [DIV_W-1:0]   div_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH:0]     sum_next_s;
    logic [PAD_W-1:0]   sum_pad_s;
    logic [3:0]         nib_s;
    logic [DIGITS:0]    zero_from_s;
    logic               blank_s;
    logic [DIGITS-1:0]  an_s;
    logic [6:0]         seg_s;

    assign sum_next_s = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.c_in};
    assign sum_pad_s  = PAD_W'(sum_r);

    // Sum capture register; holding load recaptures every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= '0;
            sum_valid_r <= 1'b0;
        end else if (bus.load) begin
            sum_r       <= sum_next_s;
            sum_valid_r <= 1'b1;
        end else begin
            sum_r       <= sum_r;
            sum_valid_r <= sum_valid_r;
        end
    end

    // Refresh divider and digit index; independent of load activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
            idx_r <= '0;
        end else if (div_r == DIV_W'(REFRESH_DIV - 1)) begin
            div_r <= '0;
            if (idx_r == IDX_W'(DIGITS - 1)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            div_r <= div_r + DIV_W'(1);
            idx_r <= idx_r;
        end
    end

    // Nibble of the active digit and "all nibbles from here up are zero" flags.
    always_comb begin
        nib_s = 4'h0;
        zero_from_s = '0;
        zero_from_s[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_from_s[k] = zero_from_s[k+1] & (sum_pad_s[4*k +: 4] == 4'h0);
        end
        blank_s = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            nib_s   = (idx_r == IDX_W'(k)) ? sum_pad_s[4*k +: 4] : nib_s;
            blank_s = (idx_r == IDX_W'(k)) ? (BLANK_LZ && (k != 0) && zero_from_s[k]) : blank_s;
        end
    end

    // Active-low one-hot anode drive and segment selection.
    always_comb begin
        an_s = '1;
        for (int k = 0; k < DIGITS; k++) begin
            an_s[k] = (idx_r != IDX_W'(k));
        end
        if (!sum_valid_r) begin
            seg_s = SEG_DASH;
        end else if (blank_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = hex_to_seg(nib_s);
        end
    end

    assign bus.sum       = sum_r;
    assign bus.sum_valid = sum_valid_r;
    assign bus.an        = an_s;
    assign bus.seg       = seg_s;
endmodule

// File: doc/adder_hex_scan_display.md
Name: adder_hex_scan_display

Overview:
Parametrised successor to the 2-bit adder/seven-segment lab block. It captures two WIDTH-bit operands plus carry-in on a load strobe and registers their (WIDTH+1)-bit sum. The sum is shown in hex on a time-multiplexed bank of DIGITS common-anode seven-segment digits, with optional leading-zero blanking. It sits between the board switches/buttons and the display pins.

Parameters:
WIDTH, 8, operand width in bits (>=2)
DIGITS, 3, number of display digits; must satisfy 4*DIGITS >= WIDTH+1 (elaboration error otherwise)
REFRESH_DIV, 4, clock cycles each digit stays enabled (>=1)
BLANK_LZ, 1, 1 = blank leading-zero digits, 0 = show all digits

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in
load  input  1  capture strobe, sampled on clk
sum  output  WIDTH+1  registered sum
sum_valid  output  1  high once any load has been captured
an  output  DIGITS  digit enables, active-low, one-hot-low
seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (async assert, sync-safe release): sum=0, sum_valid=0, divider=0, digit index=0, an={all 1s except bit0=0}, seg=7'b0111111 (dash).
- Load: when load=1 at a clk edge, sum <= a+b+c_in (zero-extended to WIDTH+1, no truncation) and sum_valid <= 1. Latency is 1 cycle. Holding load recaptures on every edge. Load does not disturb the scan.
- Divider counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the digit index advances. The index wraps from DIGITS-1 to 0.
- an and seg are combinational from the registered index and sum. Only an[idx] is low.
- Digit k shows nibble sum[4k+3:4k], zero-padded above bit WIDTH.
- Hex decode (active-low gfedcba):
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000,
  8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- sum_valid=0: every digit shows dash 0111111.
- BLANK_LZ=1: digit k>0 shows 1111111 when all nibbles k..DIGITS-1 are zero. Digit 0 is never blanked, so a zero sum shows "0".
- Reset mid-scan: immediately returns to reset state. A load in the same edge as reset deassertion is ignored only if rst_n is still low at that edge.

Test Plan (WIDTH=8, DIGITS=3, REFRESH_DIV=4, BLANK_LZ=1):
1. Reset held, then released with no load -> an=110, seg=0111111, sum_valid=0. After 4 clks an=101, after 8 an=011, after 12 an=110; seg stays dash throughout.
2. a=8'h12, b=8'h34, c_in=0, load pulse 1 cycle -> next cycle sum=9'h046, sum_valid=1. Across the scan: digit0 seg=0000010, digit1 seg=0011001, digit2 seg=1111111 (blanked).
3. a=8'hFF, b=8'h01, c_in=1, load -> sum=9'h101. Digits 0,1,2 show 1111001, 1000000, 1111001 (the middle zero is not blanked).
4. a=0, b=0, c_in=0, load -> sum=0. Digit0 shows 1000000; digits 1 and 2 show 1111111.
5. Load held for 3 cycles while a increments 1,2,3 (b=0, c_in=0) -> sum follows 1,2,3 one cycle behind, and the scan divider is not reset.
6. Assert rst_n low mid-scan (index=2) with sum=9'h101 -> same cycle: sum=0, sum_valid=0, an=110, seg=0111111.
